instrn_encoder: RTL and testbench

- Packs decoded instruction fields into 15-bit instruction words and writes them sequentially into instruction memory.
- It is the load-side counterpart of the instruction decoder.
- Word format (MSB→LSB): opcode[14:10], operand_addr_mode[9:8], operand_addr[7:4], branch_offset_value[3:0].
- Field tuples enter on a valid/ready handshake, are buffered in a small FIFO, and drain to a memory write port with an auto-incrementing address. A done flag is raised when the last word of a program is committed.

---
 rtl/instrn_encoder_pkg.sv | 36 +++
 rtl/instrn_word_fifo.sv | 61 ++++++
 rtl/instrn_encoder.sv | 123 ++++++++++++
 tb/tb_instrn_encoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instrn_encoder_pkg.sv
// Shared instruction-word layout for the encoder and decoder, plus the encoder state set.
package instrn_encoder_pkg;

  localparam int INSTR_W  = 15;
  localparam int OPC_MSB  = 14;
  localparam int OPC_LSB  = 10;
  localparam int MODE_MSB = 9;
  localparam int MODE_LSB = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 4;
  localparam int OFF_MSB  = 3;
  localparam int OFF_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } enc_state_e;

  function automatic logic [INSTR_W-1:0] pack_instr(
    input logic [4:0] opc,
    input logic [1:0] mode,
    input logic [3:0] addr,
    input logic [3:0] off
  );
    logic [INSTR_W-1:0] w;
    w                    = '0;
    w[OPC_MSB:OPC_LSB]   = opc;
    w[MODE_MSB:MODE_LSB] = mode;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[OFF_MSB:OFF_LSB]   = off;
    return w;
  endfunction

endpackage

// File: rtl/instrn_word_fifo.sv
// Synchronous FIFO holding encoded words between the field handshake and the memory port.
module instrn_word_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instrn_encoder.sv
// Packs instruction fields into 15-bit words, buffers them and writes them to
// consecutive instruction-memory addresses starting at a latched base.
module instrn_encoder
  import instrn_encoder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               field_valid,
  output logic               field_ready,
  input  logic [4:0]         opcode,
  input  logic [1:0]         operand_addr_mode,
  input  logic [3:0]         operand_addr,
  input  logic [3:0]         branch_offset_value,
  input  logic               prog_end,
  input  logic               mem_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               done,
  output logic               overflow,
  output logic [ADDR_W:0]    instr_count
);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  enc_state_e         state_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic [ADDR_W:0]    instr_count_q;
  logic               mem_we_q;
  logic               done_q;
  logic               overflow_q;

  logic [INSTR_W-1:0] new_word;
  logic [INSTR_W-1:0] head_word;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign new_word    = pack_instr(opcode, operand_addr_mode, operand_addr, branch_offset_value);
  assign field_ready = (state_q == S_LOAD) & ~fifo_full & ~overflow_q;
  assign push        = field_valid & field_ready;
  assign pop         = ~fifo_empty & mem_ready & ~overflow_q;

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign instr_count = instr_count_q;

  // Once the address space is exhausted the buffered words are thrown away.
  instrn_word_fifo #(
    .W     (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (overflow_q),
    .push_i  (push),
    .wdata_i (new_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Control FSM and registered memory write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      waddr_q       <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instr_count_q <= '0;
      mem_we_q      <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (pop) begin
        mem_we_q      <= 1'b1;
        mem_addr_q    <= waddr_q;
        mem_wdata_q   <= head_word;
        waddr_q       <= waddr_q + ADDR_ONE;
        instr_count_q <= instr_count_q + CNT_ONE;
        if (waddr_q == ADDR_LAST) overflow_q <= 1'b1;
      end else begin
        mem_we_q <= 1'b0;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_LOAD;
            waddr_q       <= base_addr;
            instr_count_q <= '0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
          end
        end
        S_LOAD: begin
          if ((push && prog_end) || overflow_q) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (fifo_empty) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instrn_encoder.sv
// Directed bench for instrn_encoder with a queue-based reference model of the write stream.
module tb_instrn_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        field_valid;
  logic        field_ready;
  logic [4:0]  opcode;
  logic [1:0]  operand_addr_mode;
  logic [3:0]  operand_addr;
  logic [3:0]  branch_offset_value;
  logic        prog_end;
  logic        mem_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [14:0] mem_wdata;
  logic        done;
  logic        overflow;
  logic [8:0]  instr_count;

  int total = 0;
  int bad   = 0;

  logic [14:0] exp_q[$];
  logic [7:0]  log_addr[$];
  logic [14:0] log_data[$];

  instrn_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .field_valid         (field_valid),
    .field_ready         (field_ready),
    .opcode              (opcode),
    .operand_addr_mode   (operand_addr_mode),
    .operand_addr        (operand_addr),
    .branch_offset_value (branch_offset_value),
    .prog_end            (prog_end),
    .mem_ready           (mem_ready),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .done                (done),
    .overflow            (overflow),
    .instr_count         (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: inputs seen at a falling edge are what the next rising edge acts on.
  initial begin
    logic        n_push  = 1'b0;
    logic        n_start = 1'b0;
    logic        n_ready = 1'b0;
    logic [14:0] n_word  = '0;
    logic [7:0]  n_base  = '0;
    logic [7:0]  m_addr  = '0;
    int          m_cnt   = 0;
    logic        m_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_addr = '0; m_cnt = 0; m_ovf = 1'b0;
        n_push = 1'b0; n_start = 1'b0; n_ready = 1'b0;
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_ready", 32'(field_ready), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
      end else begin
        if (n_start) begin
          exp_q.delete();
          m_addr = n_base; m_cnt = 0; m_ovf = 1'b0;
        end
        if (mem_we) begin
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_wdata);
          chk("we_while_stalled", 32'(n_ready), 32'd1);
          chk("we_after_overflow", 32'(m_ovf), 32'd0);
          chk("we_with_no_word", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("wdata", 32'(mem_wdata), 32'(exp_q.pop_front()));
          chk("waddr", 32'(mem_addr), 32'(m_addr));
          m_cnt++;
          if (m_addr == 8'hFF) begin
            m_ovf = 1'b1;
            exp_q.delete();
          end
          m_addr = m_addr + 8'd1;
        end
        chk("count", 32'(instr_count), 32'(m_cnt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (n_push && !m_ovf) exp_q.push_back(n_word);
        n_push  = field_valid & field_ready;
        n_word  = {opcode, operand_addr_mode, operand_addr, branch_offset_value};
        n_start = start;
        n_base  = base_addr;
        n_ready = mem_ready;
      end
    end
  end

  task automatic do_start(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push(input logic [4:0] o, input logic [1:0] m, input logic [3:0] a,
                      input logic [3:0] f, input logic last, output logic acc);
    opcode = o; operand_addr_mode = m; operand_addr = a; branch_offset_value = f;
    prog_end = last; field_valid = 1'b1; acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = field_ready;
      @(posedge clk); #1;
    end
    field_valid = 1'b0; prog_end = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(n < budget), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   b;
    rst = 1'b1; start = 1'b0; base_addr = '0; field_valid = 1'b0;
    opcode = '0; operand_addr_mode = '0; operand_addr = '0; branch_offset_value = '0;
    prog_end = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single encode
    mem_ready = 1'b1;
    do_start(8'h10);
    push(5'b10011, 2'b01, 4'hA, 4'h3, 1'b1, acc);
    chk("t1_accept", 32'(acc), 32'd1);
    wait_done(40);
    chk("t1_nwrites", 32'(log_addr.size()), 32'd1);
    chk("t1_addr", 32'(log_addr[0]), 32'h10);
    chk("t1_wdata", 32'(log_data[0]), 32'h4DA3);
    chk("t1_count", 32'(instr_count), 32'd1);
    chk("t1_done", 32'(done), 32'd1);

    // Backpressure: five tuples into a four-entry buffer
    mem_ready = 1'b0;
    do_start(8'h20);
    b = log_addr.size();
    for (int i = 0; i < 4; i++) begin
      push(5'(i + 1), 2'(i), 4'(i + 5), 4'(15 - i), 1'b0, acc);
      chk("t2_accept", 32'(acc), 32'd1);
    end
    chk("t2_ready_when_full", 32'(field_ready), 32'd0);
    mem_ready = 1'b1;
    push(5'd31, 2'd3, 4'd9, 4'd0, 1'b1, acc);
    chk("t2_accept5", 32'(acc), 32'd1);
    wait_done(60);
    chk("t2_count", 32'(instr_count), 32'd5);
    chk("t2_nwrites", 32'(log_addr.size() - b), 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_addr", 32'(log_addr[b + i]), 32'(8'h20 + i));
    chk("t2_first_word", 32'(log_data[b]), 32'h045F);
    chk("t2_last_word", 32'(log_data[b + 4]), 32'h7F90);

    // Stall mid-stream with mem_ready toggling every cycle
    mem_ready = 1'b1;
    do_start(8'h30);
    b = log_addr.size();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(5'(3 * i + 2), 2'(i + 1), 4'(2 * i + 1), 4'(i + 8), 1'(i == 5), acc);
        end
      end
      begin
        repeat (60) begin
          @(posedge clk); #1;
          mem_ready = ~mem_ready;
        end
      end
    join
    mem_ready = 1'b1;
    wait_done(60);
    chk("t3_count", 32'(instr_count), 32'd6);
    chk("t3_nwrites", 32'(log_addr.size() - b), 32'd6);
    for (int i = 0; i < 6; i++) chk("t3_addr", 32'(log_addr[b + i]), 32'(8'h30 + i));

    // Address wrap
    mem_ready = 1'b1;
    do_start(8'hFE);
    b = log_addr.size();
    for (int i = 0; i < 3; i++) push(5'(i + 4), 2'd2, 4'(i), 4'(i + 1), 1'b0, acc);
    push(5'd7, 2'd0, 4'd7, 4'd7, 1'b1, acc);
    chk("t4_rejected_after_overflow", 32'(acc), 32'd0);
    wait_done(60);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_count", 32'(instr_count), 32'd2);
    chk("t4_nwrites", 32'(log_addr.size() - b), 32'd2);
    chk("t4_addr0", 32'(log_addr[b]), 32'hFE);
    chk("t4_addr1", 32'(log_addr[b + 1]), 32'hFF);
    chk("t4_ready_low", 32'(field_ready), 32'd0);

    // Restart after done
    do_start(8'h40);
    chk("t5_done_clr", 32'(done), 32'd0);
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    chk("t5_count_clr", 32'(instr_count), 32'd0);
    b = log_addr.size();
    push(5'd1, 2'd1, 4'd1, 4'd1, 1'b1, acc);
    wait_done(40);
    chk("t5_nwrites", 32'(log_addr.size() - b), 32'd1);
    chk("t5_addr", 32'(log_addr[b]), 32'h40);
    chk("t5_wdata", 32'(log_data[b]), 32'h0511);

    // Asynchronous reset while words are queued and memory is stalled
    mem_ready = 1'b0;
    do_start(8'h50);
    for (int i = 0; i < 3; i++) push(5'(i + 9), 2'd3, 4'(i + 2), 4'd5, 1'(i == 2), acc);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_addr", 32'(mem_addr), 32'd0);
    chk("t6_wdata", 32'(mem_wdata), 32'd0);
    chk("t6_count", 32'(instr_count), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_ready", 32'(field_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    b = log_addr.size();
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_writes_after_rst", 32'(log_addr.size() - b), 32'd0);
    do_start(8'h70);
    push(5'd2, 2'd0, 4'd3, 4'd4, 1'b1, acc);
    wait_done(40);
    chk("t6_new_addr", 32'(log_addr[b]), 32'h70);
    chk("t6_new_count", 32'(instr_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
